// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the multicycle CPU sequencer: opcodes, state
// encodings, register/write-back selects and memory commands.
package cpu_pkg;

  localparam int ST_W = 5;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [3:0] VSEL_NONE   = 4'b0000;
  localparam logic [3:0] VSEL_MDATA  = 4'b0001;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
  localparam logic [3:0] VSEL_PC     = 4'b0100;
  localparam logic [3:0] VSEL_C      = 4'b1000;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_RST     = 5'd0,
    S_IF1     = 5'd1,
    S_IF2     = 5'd2,
    S_UPD_PC  = 5'd3,
    S_DECODE  = 5'd4,
    S_WR_IMM  = 5'd5,
    S_GET_A   = 5'd6,
    S_GET_B   = 5'd7,
    S_EXEC    = 5'd8,
    S_WR_REG  = 5'd9,
    S_CMP_EX  = 5'd10,
    S_ADDR    = 5'd11,
    S_LD_ADDR = 5'd12,
    S_MEM_RD  = 5'd13,
    S_WR_MEM  = 5'd14,
    S_GET_RD  = 5'd15,
    S_ST_EX   = 5'd16,
    S_MEM_WR  = 5'd17,
    S_HALT    = 5'd18
  } state_t;

  // Instruction class latched in DECODE; steers shared states later on.
  typedef enum logic [2:0] {
    INS_MOVI  = 3'd0,
    INS_SHIFT = 3'd1,
    INS_ALU   = 3'd2,
    INS_CMP   = 3'd3,
    INS_LDR   = 3'd4,
    INS_STR   = 3'd5,
    INS_HALT  = 3'd6
  } ins_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between the sequencer (master) and the CPU datapath/memory
// (slave). mem_ready exists only when CPU_SEQ_MEM_WAIT_EN is defined.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int STATE_W = ST_W
);
  logic [2:0]         opcode;
  logic [1:0]         op;
`ifdef CPU_SEQ_MEM_WAIT_EN
  logic               mem_ready;
`endif
  logic [2:0]         nsel;
  logic [3:0]         vsel;
  logic               write;
  logic               loada;
  logic               loadb;
  logic               loadc;
  logic               loads;
  logic               asel;
  logic               bsel;
  logic               loadir;
  logic               loadpc;
  logic               reset_pc;
  logic               addr_sel;
  logic               load_addr;
  logic [1:0]         mem_cmd;
  logic               halted;
  logic [STATE_W-1:0] state_out;

  modport master (
    input  opcode, op,
`ifdef CPU_SEQ_MEM_WAIT_EN
    input  mem_ready,
`endif
    output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           loadir, loadpc, reset_pc, addr_sel, load_addr, mem_cmd,
           halted, state_out
  );

  modport slave (
    output opcode, op,
`ifdef CPU_SEQ_MEM_WAIT_EN
    output mem_ready,
`endif
    input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           loadir, loadpc, reset_pc, addr_sel, load_addr, mem_cmd,
           halted, state_out
  );

endinterface

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction decode: {opcode, op} -> first execute state,
// instruction class and an illegal-encoding flag.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output state_t     first_state,
  output ins_t       ins,
  output logic       illegal
);

  always_comb begin
    first_state = S_HALT;
    ins         = INS_HALT;
    illegal     = 1'b1;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM) begin
          first_state = S_WR_IMM;
          ins         = INS_MOVI;
          illegal     = 1'b0;
        end else if (op == OP_MOV_REG) begin
          first_state = S_GET_B;
          ins         = INS_SHIFT;
          illegal     = 1'b0;
        end
      end
      OPC_ALU: begin
        illegal = 1'b0;
        case (op)
          OP_MVN: begin
            first_state = S_GET_B;
            ins         = INS_SHIFT;
          end
          OP_CMP: begin
            first_state = S_GET_A;
            ins         = INS_CMP;
          end
          default: begin
            first_state = S_GET_A;
            ins         = INS_ALU;
          end
        endcase
      end
      OPC_LDR: begin
        if (op == OP_MEM) begin
          first_state = S_GET_A;
          ins         = INS_LDR;
          illegal     = 1'b0;
        end
      end
      OPC_STR: begin
        if (op == OP_MEM) begin
          first_state = S_GET_A;
          ins         = INS_STR;
          illegal     = 1'b0;
        end
      end
      OPC_HALT: begin
        first_state = S_HALT;
        ins         = INS_HALT;
        illegal     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control FSM for the 16-bit RISC CPU: fetch, decode, ALU,
// load/store and halt. CPU_SEQ_MEM_WAIT_EN adds mem_ready wait states.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int STATE_W = ST_W
) (
  input  logic             clk,
  input  logic             reset,
  cpu_sequencer_if.master  bus
);

  state_t state_q, state_d;
  ins_t   ins_q, ins_d;
  state_t dec_state;
  ins_t   dec_ins;
  logic   dec_illegal;
  logic   mem_ok;

`ifdef CPU_SEQ_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  cpu_seq_decode u_decode (
    .opcode      (bus.opcode),
    .op          (bus.op),
    .first_state (dec_state),
    .ins         (dec_ins),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      ins_q   <= INS_HALT;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
    end
  end

  assign bus.state_out = STATE_W'(state_q);

  always_comb begin
    state_d       = state_q;
    ins_d         = ins_q;
    bus.nsel      = NSEL_NONE;
    bus.vsel      = VSEL_NONE;
    bus.write     = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.loadir    = 1'b0;
    bus.loadpc    = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.load_addr = 1'b0;
    bus.mem_cmd   = MEM_NONE;
    bus.halted    = 1'b0;

    case (state_q)
      S_RST: begin
        bus.reset_pc = 1'b1;
        bus.loadpc   = 1'b1;
        state_d      = S_IF1;
      end
      S_IF1: begin
        bus.addr_sel = 1'b1;
        bus.mem_cmd  = MEM_READ;
        state_d      = S_IF2;
      end
      S_IF2: begin
        bus.addr_sel = 1'b1;
        bus.mem_cmd  = MEM_READ;
        bus.loadir   = mem_ok;
        if (mem_ok) state_d = S_UPD_PC;
      end
      S_UPD_PC: begin
        bus.loadpc = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Only cycle in which opcode/op are looked at.
        state_d = dec_illegal ? S_HALT   : dec_state;
        ins_d   = dec_illegal ? INS_HALT : dec_ins;
      end
      S_WR_IMM: begin
        bus.nsel  = NSEL_RN;
        bus.vsel  = VSEL_SXIMM8;
        bus.write = 1'b1;
        state_d   = S_IF1;
      end
      S_GET_A: begin
        bus.nsel  = NSEL_RN;
        bus.loada = 1'b1;
        state_d   = (ins_q == INS_LDR || ins_q == INS_STR) ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        bus.nsel  = NSEL_RM;
        bus.loadb = 1'b1;
        state_d   = (ins_q == INS_CMP) ? S_CMP_EX : S_EXEC;
      end
      S_EXEC: begin
        // MOV reg / MVN pass B through the ALU with A forced to zero.
        bus.asel  = (ins_q == INS_SHIFT);
        bus.loadc = 1'b1;
        state_d   = S_WR_REG;
      end
      S_WR_REG: begin
        bus.nsel  = NSEL_RD;
        bus.vsel  = VSEL_C;
        bus.write = 1'b1;
        state_d   = S_IF1;
      end
      S_CMP_EX: begin
        bus.loads = 1'b1;
        state_d   = S_IF1;
      end
      S_ADDR: begin
        bus.bsel  = 1'b1;
        bus.loadc = 1'b1;
        state_d   = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        bus.load_addr = 1'b1;
        state_d       = (ins_q == INS_STR) ? S_GET_RD : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_cmd = MEM_READ;
        state_d     = S_WR_MEM;
      end
      S_WR_MEM: begin
        bus.mem_cmd = MEM_READ;
        bus.nsel    = NSEL_RD;
        bus.vsel    = VSEL_MDATA;
        bus.write   = mem_ok;
        if (mem_ok) state_d = S_IF1;
      end
      S_GET_RD: begin
        bus.nsel  = NSEL_RD;
        bus.loadb = 1'b1;
        state_d   = S_ST_EX;
      end
      S_ST_EX: begin
        bus.asel  = 1'b1;
        bus.loadc = 1'b1;
        state_d   = S_MEM_WR;
      end
      S_MEM_WR: begin
        bus.mem_cmd = MEM_WRITE;
        if (mem_ok) state_d = S_IF1;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multicycle FSM controller for the 16-bit simple RISC CPU.
- Fetches each instruction from memory, updates the PC, decodes opcode/op, and drives every datapath and memory control strobe (register file, A/B/C/status registers, address register, IR, PC) one state per cycle.
- Instantiated inside CPU between the instruction register and the datapath.
- Replaces the ad-hoc control logic, so fetch, ALU, load/store and halt are sequenced from one place.

Parameters:
- STATE_W, 5, width of state register and of the state_out debug port.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state RST
- opcode  input  3  IR[15:13]
- op  input  2  IR[12:11]
- nsel  output  3  one-hot register-field select: 001 Rn, 010 Rd, 100 Rm; 000 when unused
- vsel  output  4  one-hot write-back source: 0001 mdata, 0010 sximm8, 0100 PC, 1000 C
- write  output  1  register-file write enable
- loada, loadb, loadc, loads  output  1 each  datapath register loads
- asel  output  1  1 = A operand forced to 0
- bsel  output  1  1 = B operand is sximm5
- loadir  output  1  IR load
- loadpc  output  1  PC load
- reset_pc  output  1  PC next-value = 0
- addr_sel  output  1  1 = memory address from PC, 0 = from address register
- load_addr  output  1  address register load
- mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE
- halted  output  1  high in HALT
- state_out  output  STATE_W  current state encoding, for debug and bench

Behaviour:
- Reset (async, any cycle, including mid-instruction): state = RST immediately. While in RST: reset_pc=1, loadpc=1; all other outputs 0.
- Defaults in every state: all strobes 0, nsel=000, vsel=0000, mem_cmd=NONE.
- Outputs are Moore (a function of state only); opcode/op are sampled only in DECODE.
- Fetch path:
  - RST -> IF1
  - IF1 (addr_sel=1, mem_cmd=READ) -> IF2
  - IF2 (addr_sel=1, mem_cmd=READ, loadir=1) -> UPD_PC
  - UPD_PC (loadpc=1) -> DECODE
  - DECODE (no strobes) -> next state by opcode/op, below.
- 110/10 MOV imm: WR_IMM (nsel=Rn, vsel=sximm8, write=1) -> IF1. Total 5 cycles.
- 110/00 MOV reg and 101/11 MVN: GET_B (nsel=Rm, loadb=1) -> EXEC (asel=1, loadc=1) -> WR_REG (nsel=Rd, vsel=C, write=1) -> IF1.
- 101/00 ADD and 101/10 AND: GET_A (nsel=Rn, loada=1) -> GET_B -> EXEC (loadc=1) -> WR_REG -> IF1.
- 101/01 CMP: GET_A -> GET_B -> CMP_EX (loads=1, loadc=0) -> IF1. No register write.
- 011/00 LDR: GET_A -> ADDR (bsel=1, loadc=1) -> LD_ADDR (load_addr=1) -> MEM_RD (addr_sel=0, mem_cmd=READ) -> WR_MEM (addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=mdata, write=1) -> IF1.
- 100/00 STR: GET_A -> ADDR -> LD_ADDR -> GET_RD (nsel=Rd, loadb=1) -> ST_EX (asel=1, loadc=1) -> MEM_WR (addr_sel=0, mem_cmd=WRITE) -> IF1.
- 111/xx HALT: enters HALT (halted=1). HALT is absorbing and is left only via reset.
- Any other opcode/op encoding is treated as HALT.
- write and mem_cmd=WRITE are never asserted in the same cycle.

Optional Feature:
- Macro: CPU_SEQ_MEM_WAIT_EN
- Defined:
  - Adds input mem_ready (1 bit).
  - IF2, WR_MEM and MEM_WR hold their outputs and state until mem_ready=1.
  - loadir and write are qualified by mem_ready, so they pulse only in the completing cycle.
  - Reset during a wait aborts the wait immediately.
- Undefined: no mem_ready port; memory has fixed 1-cycle latency as described above.

Decomposition:
- Package cpu_pkg:
  - opcode/op localparams
  - state encodings (STATE_W wide)
  - nsel, vsel and mem_cmd constants
- Optional sub-module cpu_seq_decode: combinational {opcode, op} -> first post-DECODE state plus illegal flag; keeps the FSM next-state logic flat.
- Everything else stays in one always_ff (state register) plus one always_comb (outputs and next state).

Test Plan:
- Reset held, then released at 15 ns -> RST for one cycle with reset_pc=1 and loadpc=1; next cycles IF1, IF2 (loadir=1), UPD_PC, DECODE.
- opcode=110, op=10 (MOV R0,#7) -> WR_IMM with nsel=001, vsel=0010, write=1, then IF1; 5 cycles from IF1 to IF1.
- ADD R2,R1,R0 with LSL (101/00) -> GET_A, GET_B, EXEC, WR_REG in order; WR_REG has nsel=010, vsel=1000; CPU datapath_out = 16 for R1=2, R0=7 shifted (2+(7<<1)).
- CMP (101/01) -> loads=1 exactly one cycle, write never asserted; STR -> mem_cmd=10 exactly one cycle with addr_sel=0.
- HALT (111) -> halted=1 held for 50 cycles with no strobes; assert reset mid-LDR in MEM_RD -> state_out=RST in the same cycle, asynchronously.
- With CPU_SEQ_MEM_WAIT_EN, mem_ready low for 3 cycles in IF2 -> state holds, loadir=0, then loadir=1 in exactly one cycle when mem_ready rises.
